chu_vga_fade_stage: RTL
=======================

// Module: chu_vga_fade_stage
// PURPOSE
//  Stream stage between the last daisy-chain video core (mouse) and chu_vga_sync_core.
//  Consumes {rgb, frame_start} beats over valid/ready and scales brightness by a 4-bit level.
//  Runs frame-locked fade-in/fade-out sequences under CPU control via its own video slot.
//  Re-emits the same {rgb, frame_start} beats to the sync core through a 2-entry buffer.
// PARAMETERS
//  CD    12   colour depth; 3 equal channels, CW = CD/3 bits each
//  LW    4    fade level width; level range 0..2**LW-1 (max = identity)
//  FPW   8    frames-per-step field width
// PORTS
//  clk       in   1      system clock; the only clock
//  reset_n   in   1      asynchronous, active-low reset
//  cs        in   1      slot select
//  write     in   1      slot write strobe; a write occurs when cs & write
//  addr      in   14     slot register address; only addr[1:0] decoded
//  wr_data   in   32     slot write data
//  si_data   in   CD+1   {rgb[CD-1:0], frame_start}
//  si_valid  in   1      upstream beat valid
//  si_ready  out  1      stage can accept a beat
//  so_data   out  CD+1   {scaled rgb, frame_start passed unchanged}
//  so_valid  out  1      output beat valid
//  so_ready  in   1      sync core accepts the beat
// BEHAVIOUR
//  Reset values: level = max, applied level = max, state IDLE, bypass = 0, buffer empty.
//   si_ready = 1, so_valid = 0, so_data = 0.
//  Registers are write-only:
//   addr 0, SET: level <= wr_data[LW-1:0]. Aborts any fade (state -> IDLE).
//   addr 1, FADE: dir = wr_data[0] (1 = in toward max, 0 = out toward 0).
//    fps = wr_data[8 +: FPW], with fps == 0 treated as 1. Frame counter clears.
//   addr 2, BYPASS: bypass <= wr_data[0]. When set, rgb passes unscaled.
//   addr 3: ignored.
//  Handshake:
//   A beat is accepted when si_valid & si_ready. Output transfers when so_valid & so_ready.
//   Buffer depth is 2. si_ready = (count < 2); so_valid = (count > 0); so_data = head entry.
//   Push and pop in the same cycle leave count unchanged. Order is strictly FIFO.
//   Latency when empty: an accepted beat appears on so_data in the next cycle.
//  Scaling:
//   Each channel c is computed as (c * (L+1)) >> LW, using CW+LW+1-bit intermediates.
//   L is the applied level. L = max gives identity; L = 0 gives c >> LW.
//  Tear-free updates: the applied level loads from level only on an accepted beat with frame_start = 1.
//   That beat is itself scaled with the newly loaded value.
//  FSM states: IDLE, FADE_IN, FADE_OUT.
//   FADE write: if level already equals the target (max for in, 0 for out), state stays IDLE.
//    Otherwise go to FADE_IN or FADE_OUT.
//   Each accepted frame_start beat while fading increments the frame counter.
//   When the counter reaches fps-1, it clears and level steps by ±1.
//   Reaching the target (max or 0) returns the FSM to IDLE.
//   Level saturates and never wraps.
//  Same-cycle events:
//   A register write takes priority over a fade step in that cycle.
//   The frame_start level load uses the level value from before that cycle's update.
//  Async reset mid-stream drops the buffer contents. The sync core resynchronises on the next frame_start.
// CONFIGURATION
//  `VGA_FADE_DONE_IRQ_EN defined: adds output port fade_done (1 bit, reset 0).
//   fade_done pulses high for exactly 1 clk when the FSM reaches its target and returns to IDLE.
//   A SET abort does not pulse it.
//  Undefined: no fade_done port and no related logic.
// STRUCTURE
//  Package chu_vga_fade_pkg:
//   fade_state_t enum {IDLE, FADE_IN, FADE_OUT}
//   Register offsets REG_SET = 0, REG_FADE = 1, REG_BYPASS = 2
//   Function scale_ch(c, L)
//  Sub-module chu_vga_fade_buf: 2-entry valid/ready FIFO, parameterised width CD+1.
//  Top level holds the register decode, FSM, frame counter, applied-level register and the scaler feeding the buffer push.
// TESTING
//  1. After reset, stream rgb 12'hF84, start = 0, so_ready = 1 -> so_data = {12'hF84, 0} one cycle later, with no bubbles.
//  2. SET level 7 mid-frame -> output stays 12'hF84 until the next start beat.
//     From that beat on, output = 12'h742 (c*8>>4).
//  3. FADE out with fps = 2 from level 15 -> level decrements every 2 frame_starts and reaches 0 after 30 frames.
//     Final output = 12'h000; FSM IDLE; fade_done pulses once when the IRQ macro is enabled.
//  4. Hold so_ready = 0 while si_valid = 1 -> exactly 2 beats accepted, then si_ready = 0.
//     Release so_ready -> beats emerge in order with no loss or duplication.
//  5. SET written while FADE_IN is in progress, in the same cycle as a fade step -> SET value wins and FSM is IDLE.
//     FADE with fps = 0 behaves exactly as fps = 1.
//  6. BYPASS = 1 at level 0 -> rgb passes unchanged.
//     Assert reset_n low mid-burst -> so_valid drops immediately and all outputs return to reset values.

Source files
------------

// File: rtl/chu_vga_fade_pkg.sv
// Shared types, register offsets and the channel scaler for the VGA fade stage.
package chu_vga_fade_pkg;

    localparam int FADE_CD  = 12;
    localparam int FADE_CW  = FADE_CD / 3;
    localparam int FADE_LW  = 4;
    localparam int FADE_FPW = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_IN  = 2'd1,
        FADE_OUT = 2'd2
    } fade_state_t;

    localparam logic [1:0] REG_SET    = 2'd0;
    localparam logic [1:0] REG_FADE   = 2'd1;
    localparam logic [1:0] REG_BYPASS = 2'd2;

    // (c * (L+1)) >> LW; the top level therefore maps to identity.
    function automatic logic [FADE_CW-1:0] scale_ch(input logic [FADE_CW-1:0] c,
                                                    input logic [FADE_LW-1:0] l);
        logic [FADE_CW+FADE_LW:0] c_w;
        logic [FADE_CW+FADE_LW:0] l_w;
        logic [FADE_CW+FADE_LW:0] prod;
        c_w      = {{(FADE_LW+1){1'b0}}, c};
        l_w      = {{(FADE_CW+1){1'b0}}, l} + {{(FADE_CW+FADE_LW){1'b0}}, 1'b1};
        prod     = c_w * l_w;
        scale_ch = prod[FADE_LW +: FADE_CW];
    endfunction

endpackage

// File: rtl/chu_vga_fade_buf.sv
// Two-entry valid/ready FIFO between the fade scaler and the sync core.
module chu_vga_fade_buf #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] push_data_i,
    input  logic         push_valid_i,
    output logic         push_ready_o,
    output logic [W-1:0] pop_data_o,
    output logic         pop_valid_o,
    input  logic         pop_ready_i
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         push_s;
    logic         pop_s;

    assign push_ready_o = (count_q < 2'd2);
    assign pop_valid_o  = (count_q != 2'd0);
    assign pop_data_o   = mem_q[rd_ptr_q];
    assign push_s       = push_valid_i & push_ready_o;
    assign pop_s        = pop_ready_i & pop_valid_o;

    // Storage, pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/chu_vga_fade_stage.sv
// Brightness fade stage for the VGA stream: register slot, frame-locked fade FSM, scaler, 2-deep buffer.
// Optional `VGA_FADE_DONE_IRQ_EN adds a one-cycle fade_done pulse when a fade reaches its target.
module chu_vga_fade_stage
    import chu_vga_fade_pkg::*;
#(
    parameter int CD  = FADE_CD,
    parameter int LW  = FADE_LW,
    parameter int FPW = FADE_FPW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cs,
    input  logic          write,
    input  logic [13:0]   addr,
    input  logic [31:0]   wr_data,
    input  logic [CD:0]   si_data,
    input  logic          si_valid,
    output logic          si_ready,
    output logic [CD:0]   so_data,
    output logic          so_valid,
    input  logic          so_ready
`ifdef VGA_FADE_DONE_IRQ_EN
    ,
    output logic          fade_done
`endif
);

    localparam int CW = CD / 3;
    localparam logic [LW-1:0]  LVL_MAX = {LW{1'b1}};
    localparam logic [LW-1:0]  LVL_ONE = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [FPW-1:0] FPS_ONE = {{(FPW-1){1'b0}}, 1'b1};

    fade_state_t    state_q, state_d;
    logic [LW-1:0]  level_q, level_d;
    logic [LW-1:0]  applied_q, applied_d;
    logic [FPW-1:0] fps_q, fps_d;
    logic [FPW-1:0] cnt_q, cnt_d;
    logic           bypass_q, bypass_d;

    logic           wr_s, set_s, fade_s, bypass_wr_s;
    logic           start_s;
    logic [LW-1:0]  l_eff_s;
    logic [CD-1:0]  rgb_s, scaled_s, rgb_out_s;
    logic           unused_s;

    assign wr_s        = cs & write;
    assign set_s       = wr_s & (addr[1:0] == REG_SET);
    assign fade_s      = wr_s & (addr[1:0] == REG_FADE);
    assign bypass_wr_s = wr_s & (addr[1:0] == REG_BYPASS);
    assign start_s     = si_valid & si_ready & si_data[0];
    assign unused_s    = ^{addr[13:2], wr_data[31:8+FPW], wr_data[7:LW]};

    // A frame-start beat is scaled with the level it loads, so the new level lands tear-free.
    assign l_eff_s = start_s ? level_q : applied_q;
    assign rgb_s   = si_data[CD:1];

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        assign scaled_s[ch*CW +: CW] = scale_ch(rgb_s[ch*CW +: CW], l_eff_s);
    end

    assign rgb_out_s = bypass_q ? rgb_s : scaled_s;

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            level_q   <= LVL_MAX;
            applied_q <= LVL_MAX;
            fps_q     <= FPS_ONE;
            cnt_q     <= '0;
            bypass_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            applied_q <= applied_d;
            fps_q     <= fps_d;
            cnt_q     <= cnt_d;
            bypass_q  <= bypass_d;
        end
    end

    // Next state: register writes win over a fade step landing in the same cycle.
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        fps_d     = fps_q;
        cnt_d     = cnt_q;
        bypass_d  = bypass_q;
        applied_d = start_s ? level_q : applied_q;
        if (set_s) begin
            level_d = wr_data[LW-1:0];
            state_d = IDLE;
        end else if (fade_s) begin
            fps_d = (wr_data[8 +: FPW] == '0) ? FPS_ONE : wr_data[8 +: FPW];
            cnt_d = '0;
            if (wr_data[0]) begin
                state_d = (level_q == LVL_MAX) ? IDLE : FADE_IN;
            end else begin
                state_d = (level_q == '0) ? IDLE : FADE_OUT;
            end
        end else if (bypass_wr_s) begin
            bypass_d = wr_data[0];
        end else if (start_s && (state_q != IDLE)) begin
            if (cnt_q == (fps_q - FPS_ONE)) begin
                cnt_d = '0;
                case (state_q)
                    FADE_IN: begin
                        if (level_q != LVL_MAX) begin
                            level_d = level_q + LVL_ONE;
                        end else begin
                            level_d = level_q;
                        end
                        state_d = (level_d == LVL_MAX) ? IDLE : FADE_IN;
                    end
                    FADE_OUT: begin
                        if (level_q != '0) begin
                            level_d = level_q - LVL_ONE;
                        end else begin
                            level_d = level_q;
                        end
                        state_d = (level_d == '0) ? IDLE : FADE_OUT;
                    end
                    default: state_d = IDLE;
                endcase
            end else begin
                cnt_d = cnt_q + FPS_ONE;
            end
        end else begin
            state_d = state_q;
        end
    end

`ifdef VGA_FADE_DONE_IRQ_EN
    logic done_q, done_d;

    // Completion only counts when the fade itself reached its target, not on a register write.
    always_comb begin
        if ((state_q != IDLE) && (state_d == IDLE) && !wr_s) begin
            done_d = 1'b1;
        end else begin
            done_d = 1'b0;
        end
    end

    // One-cycle completion pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign fade_done = done_q;
`endif

    chu_vga_fade_buf #(
        .W (CD + 1)
    ) u_buf (
        .clk          (clk),
        .reset_n      (reset_n),
        .push_data_i  ({rgb_out_s, si_data[0]}),
        .push_valid_i (si_valid),
        .push_ready_o (si_ready),
        .pop_data_o   (so_data),
        .pop_valid_o  (so_valid),
        .pop_ready_i  (so_ready)
    );

endmodule
